mem_fill_responder: RTL and testbench

MEM_FILL_RESPONDER -- requirements
Module: mem_fill_responder

---
 rtl/mem_fill_responder.sv | 164 ++++++++++++++++
 tb/tb_mem_fill_responder.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_fill_responder.sv
// Word-addressed responder: writes commit at accept, reads return after a fixed LATENCY.
// Optional block-fill burst reads are enabled by defining FILL_BURST_EN.
module mem_fill_responder #(
  parameter int unsigned LATENCY    = 4,
  parameter int unsigned WORDS_LOG2 = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  input  logic        req_wr,
  input  logic [15:0] req_addr,
  input  logic [15:0] req_wdata,
  input  logic        req_burst,
  output logic        req_ready,
  output logic [15:0] memory_data,
  output logic        memory_data_valid,
  output logic [15:0] memory_data_addr
);

  localparam int unsigned DW         = 16;
  localparam int unsigned AW         = 16;
  localparam int unsigned DEPTH      = 1 << WORDS_LOG2;
  localparam int unsigned STAGES     = LATENCY - 1;
  localparam logic [AW-1:0] BLOCK_MASK = 16'hFFF0;

  logic                  accept_c;
  logic                  rd_c;
  logic                  wr_c;
  logic                  burst_go_c;
  logic                  issue_c;
  logic [AW-1:0]         issue_addr_c;
  logic                  ready_nxt;
  logic                  pipe_in_v;
  logic [AW-1:0]         pipe_in_addr;
  logic [DW-1:0]         pipe_in_data;
  logic [WORDS_LOG2-1:0] rd_idx;
  logic [WORDS_LOG2-1:0] wr_idx;
  logic                  unused_ok;

  logic [DW-1:0]         mem [DEPTH];
  logic [STAGES-1:0]     pv;
  logic [DW-1:0]         pd [STAGES];
  logic [AW-1:0]         pa [STAGES];

  assign accept_c  = req_valid & req_ready;
  assign rd_c      = accept_c & ~req_wr;
  assign wr_c      = accept_c & req_wr;
  assign unused_ok = ^{req_burst, req_addr[0]};

`ifdef FILL_BURST_EN
  typedef enum logic [1:0] {IDLE = 2'd0, LAT = 2'd1, STREAM = 2'd2} state_t;
  localparam int unsigned CNT_W = 5;

  state_t          state;
  state_t          state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [AW-1:0]    base;
  logic [AW-1:0]    base_nxt;

  assign burst_go_c = rd_c & req_burst;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      base  <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      base  <= base_nxt;
    end
  end

  // cnt holds cycles elapsed since the burst was accepted; word k is issued at cnt == k
  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    base_nxt     = base;
    issue_c      = 1'b0;
    issue_addr_c = base + AW'({cnt[2:0], 1'b0});
    case (state)
      IDLE: begin
        if (burst_go_c) begin
          state_nxt = LAT;
          cnt_nxt   = CNT_W'(1);
          base_nxt  = req_addr & BLOCK_MASK;
        end
      end
      LAT: begin
        issue_c = (cnt <= CNT_W'(7));
        cnt_nxt = cnt + CNT_W'(1);
        if (cnt == CNT_W'(LATENCY - 1)) state_nxt = STREAM;
      end
      STREAM: begin
        issue_c = (cnt <= CNT_W'(7));
        cnt_nxt = cnt + CNT_W'(1);
        if (cnt == CNT_W'(LATENCY + 7)) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    ready_nxt = (state_nxt == IDLE);
  end
`else
  assign burst_go_c   = 1'b0;
  assign issue_c      = 1'b0;
  assign issue_addr_c = '0;
  assign ready_nxt    = 1'b1;
`endif

  // Select what enters the read pipeline this cycle
  always_comb begin
    pipe_in_v    = 1'b0;
    pipe_in_addr = {req_addr[15:1], 1'b0};
    if (burst_go_c) begin
      pipe_in_v    = 1'b1;
      pipe_in_addr = req_addr & BLOCK_MASK;
    end else if (rd_c) begin
      pipe_in_v    = 1'b1;
    end else if (issue_c) begin
      pipe_in_v    = 1'b1;
      pipe_in_addr = issue_addr_c;
    end
  end

  assign rd_idx       = pipe_in_addr[WORDS_LOG2:1];
  assign wr_idx       = req_addr[WORDS_LOG2:1];
  assign pipe_in_data = mem[rd_idx];

  // Storage is intentionally not reset
  always_ff @(posedge clk) begin
    if (wr_c) mem[wr_idx] <= req_wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pv <= '0;
      for (int i = 0; i < STAGES; i++) begin
        pd[i] <= '0;
        pa[i] <= '0;
      end
      memory_data_valid <= 1'b0;
      memory_data       <= '0;
      memory_data_addr  <= '0;
      req_ready         <= 1'b1;
    end else begin
      pv[0] <= pipe_in_v;
      pd[0] <= pipe_in_data;
      pa[0] <= pipe_in_addr;
      for (int i = 1; i < STAGES; i++) begin
        pv[i] <= pv[i-1];
        pd[i] <= pd[i-1];
        pa[i] <= pa[i-1];
      end
      memory_data_valid <= pv[STAGES-1];
      if (pv[STAGES-1]) begin
        memory_data      <= pd[STAGES-1];
        memory_data_addr <= pa[STAGES-1];
      end
      req_ready <= ready_nxt;
    end
  end

endmodule

// File: tb/tb_mem_fill_responder.sv
// Bench for mem_fill_responder: per-cycle comparison against a behavioural model plus literal checks.
module tb_mem_fill_responder;
  localparam int unsigned LAT   = 4;
  localparam int unsigned WL2   = 10;
  localparam int          DEPTH = 1 << WL2;
  localparam int          NC    = 512;
`ifdef FILL_BURST_EN
  localparam bit BURST = 1'b1;
`else
  localparam bit BURST = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_wr;
  logic [15:0] req_addr;
  logic [15:0] req_wdata;
  logic        req_burst;
  logic        req_ready;
  logic [15:0] memory_data;
  logic        memory_data_valid;
  logic [15:0] memory_data_addr;

  mem_fill_responder #(.LATENCY(LAT), .WORDS_LOG2(WL2)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_wr(req_wr),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_burst(req_burst),
    .req_ready(req_ready), .memory_data(memory_data),
    .memory_data_valid(memory_data_valid), .memory_data_addr(memory_data_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = -1;
  int n_pass = 0;
  int n_total = 0;

  logic [15:0] shadow    [DEPTH];
  bit          shadow_ok [DEPTH];
  bit          exp_v     [NC];
  logic [15:0] exp_d     [NC];
  bit          exp_dk    [NC];
  logic [15:0] exp_a     [NC];
  bit          exp_ready [NC];
  bit          exp_rst   [NC];
  bit          obs_v     [NC];
  logic [15:0] obs_d     [NC];
  logic [15:0] obs_a     [NC];
  bit          obs_r     [NC];

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] want);
    n_total++;
    if (act === want) n_pass++;
    else $display("FAIL %s: got 0x%04h, expected 0x%04h (now cycle %0d)", nm, act, want, cyc);
  endtask

  function automatic int widx(input logic [15:0] a);
    return (int'(a) / 2) % DEPTH;
  endfunction

  task automatic sched(input int c, input logic [15:0] a);
    int i;
    i = widx(a);
    if (c < NC) begin
      exp_v[c]  = 1'b1;
      exp_d[c]  = shadow[i];
      exp_dk[c] = shadow_ok[i];
      exp_a[c]  = a;
    end
  endtask

  // Model: what the request of cycle c means for later cycles
  task automatic model_step();
    int c;
    logic [15:0] base;
    c = cyc;
    if (c >= 0 && c < NC) begin
      if (!rst_n) begin
        for (int k = c + 1; k < NC; k++) begin
          exp_v[k]     = 1'b0;
          exp_ready[k] = 1'b1;
        end
        if (c + 1 < NC) exp_rst[c+1] = 1'b1;
      end else if (req_valid && exp_ready[c]) begin
        if (req_wr) begin
          shadow[widx(req_addr)]    = req_wdata;
          shadow_ok[widx(req_addr)] = 1'b1;
        end else if (BURST && req_burst) begin
          base = req_addr & 16'hFFF0;
          for (int k = 0; k < 8; k++) sched(c + int'(LAT) + k, base + 16'(2 * k));
          for (int k = c + 1; k <= c + int'(LAT) + 7 && k < NC; k++) exp_ready[k] = 1'b0;
        end else begin
          sched(c + int'(LAT), req_addr & 16'hFFFE);
        end
      end
    end
  endtask

  initial begin
    for (int k = 0; k < NC; k++) exp_ready[k] = 1'b1;
    forever begin
      @(posedge clk);
      #8;
      model_step();
    end
  end

  // Compare process: outputs of every cycle against the model
  initial begin
    logic [15:0] hold_d;
    bit hold_k;
    hold_d = 16'h0000;
    hold_k = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (cyc < NC) begin
        obs_v[cyc] = memory_data_valid;
        obs_d[cyc] = memory_data;
        obs_a[cyc] = memory_data_addr;
        obs_r[cyc] = req_ready;
        if (exp_rst[cyc]) begin
          hold_d = 16'h0000;
          hold_k = 1'b1;
        end
        chk("valid", 16'(memory_data_valid), 16'(exp_v[cyc]));
        if (exp_v[cyc]) begin
          if (exp_dk[cyc]) chk("data", memory_data, exp_d[cyc]);
          chk("addr", memory_data_addr, exp_a[cyc]);
          hold_d = exp_d[cyc];
          hold_k = exp_dk[cyc];
        end else if (hold_k) begin
          chk("hold", memory_data, hold_d);
        end
        chk("ready", 16'(req_ready), 16'(exp_ready[cyc]));
      end
    end
  end

  task automatic drive(input logic v, input logic w, input logic [15:0] a,
                       input logic [15:0] d, input logic b);
    @(posedge clk);
    #2;
    req_valid = v; req_wr = w; req_addr = a; req_wdata = d; req_burst = b;
  endtask

  task automatic wr(input logic [15:0] a, input logic [15:0] d);
    drive(1'b1, 1'b1, a, d, 1'b0);
  endtask

  task automatic rd(input logic [15:0] a);
    drive(1'b1, 1'b0, a, 16'h0000, 1'b0);
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0);
  endtask

  int b;
  int r;

  initial begin
    rst_n = 1'b0;
    req_valid = 1'b0; req_wr = 1'b0; req_addr = 16'h0000; req_wdata = 16'h0000; req_burst = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    chk("rst_valid", 16'(memory_data_valid), 16'h0000);
    chk("rst_data",  memory_data, 16'h0000);
    chk("rst_addr",  memory_data_addr, 16'h0000);
    chk("rst_ready", 16'(req_ready), 16'h0001);
    idle(1);
    rst_n = 1'b1;
    idle(2);

    // write then read of the same word
    wr(16'h0010, 16'hBEEF); b = cyc;
    rd(16'h0010);
    idle(7);
    chk("w_r_valid_before", 16'(obs_v[b+4]), 16'h0000);
    chk("w_r_valid", 16'(obs_v[b+5]), 16'h0001);
    chk("w_r_data", obs_d[b+5], 16'hBEEF);
    chk("w_r_addr", obs_a[b+5], 16'h0010);
    chk("w_r_valid_after", 16'(obs_v[b+6]), 16'h0000);
    chk("model_w_r", exp_d[b+5], 16'hBEEF);

    // back-to-back reads
    wr(16'h0000, 16'h1111);
    wr(16'h0002, 16'h2222);
    wr(16'h0004, 16'h3333);
    rd(16'h0000); b = cyc;
    rd(16'h0002);
    rd(16'h0004);
    idle(6);
    chk("b2b_idle", 16'(obs_v[b+3]), 16'h0000);
    chk("b2b_d0", obs_d[b+4], 16'h1111);
    chk("b2b_d1", obs_d[b+5], 16'h2222);
    chk("b2b_d2", obs_d[b+6], 16'h3333);
    chk("b2b_a2", obs_a[b+6], 16'h0004);
    chk("b2b_end", 16'(obs_v[b+7]), 16'h0000);

    // read in flight sees old data, later read sees new data
    wr(16'h0020, 16'hAAAA);
    rd(16'h0020); b = cyc;
    wr(16'h0020, 16'h5555);
    rd(16'h0020);
    idle(6);
    chk("raw_old", obs_d[b+4], 16'hAAAA);
    chk("raw_gap", 16'(obs_v[b+5]), 16'h0000);
    chk("raw_new_v", 16'(obs_v[b+6]), 16'h0001);
    chk("raw_new", obs_d[b+6], 16'h5555);
    chk("hold_v", 16'(obs_v[b+8]), 16'h0000);
    chk("hold_d", obs_d[b+8], 16'h5555);

    // aliasing above WORDS_LOG2 and odd byte address
    wr(16'h0012, 16'h7777);
    rd(16'h0812); b = cyc;
    wr(16'h0814, 16'h4321);
    rd(16'h0014);
    rd(16'h0013);
    idle(6);
    chk("alias_rd_d", obs_d[b+4], 16'h7777);
    chk("alias_rd_a", obs_a[b+4], 16'h0812);
    chk("alias_wr_d", obs_d[b+6], 16'h4321);
    chk("odd_d", obs_d[b+7], 16'h7777);
    chk("odd_a", obs_a[b+7], 16'h0012);

    // burst flag on a write is a plain write
    drive(1'b1, 1'b1, 16'h0030, 16'h0C0C, 1'b1); b = cyc;
    rd(16'h0030);
    idle(6);
    chk("wburst_ready", 16'(obs_r[b+1]), 16'h0001);
    chk("wburst_d", obs_d[b+5], 16'h0C0C);

`ifndef FILL_BURST_EN
    // burst flag ignored on reads without the burst feature
    drive(1'b1, 1'b0, 16'h0012, 16'h0000, 1'b1); b = cyc;
    idle(7);
    chk("nob_ready", 16'(obs_r[b+1]), 16'h0001);
    chk("nob_v", 16'(obs_v[b+4]), 16'h0001);
    chk("nob_d", obs_d[b+4], 16'h7777);
    chk("nob_single", 16'(obs_v[b+5]), 16'h0000);
`endif

    // reset discards in-flight read, keeps storage
    wr(16'h0040, 16'h9999);
    rd(16'h0040); b = cyc;
    idle(1);
    idle(1); rst_n = 1'b0;
    idle(1); rst_n = 1'b1;
    idle(2);
    rd(16'h0040);
    idle(6);
    chk("rst_mid_d", obs_d[b+3], 16'h0000);
    chk("rst_drop_v", 16'(obs_v[b+4]), 16'h0000);
    chk("rst_drop_d", obs_d[b+4], 16'h0000);
    chk("model_rst", 16'(exp_v[b+4]), 16'h0000);
    chk("rst_keep_v", 16'(obs_v[b+10]), 16'h0001);
    chk("rst_keep_d", obs_d[b+10], 16'h9999);

`ifdef FILL_BURST_EN
    // burst fill with a single read ahead of it and a dropped write inside it
    for (int k = 0; k < 8; k++) wr(16'h0100 + 16'(2 * k), 16'hB000 + 16'(k));
    rd(16'h0000);
    drive(1'b1, 1'b0, 16'h0106, 16'h0000, 1'b1); b = cyc;
    for (int k = 1; k <= 11; k++) begin
      if (k == 5) wr(16'h0100, 16'hDEAD);
      else idle(1);
    end
    rd(16'h0100); r = cyc;
    idle(6);
    chk("bst_single_v", 16'(obs_v[b+3]), 16'h0001);
    chk("bst_single_d", obs_d[b+3], 16'h1111);
    for (int k = 0; k < 8; k++) begin
      chk("bst_v", 16'(obs_v[b+4+k]), 16'h0001);
      chk("bst_d", obs_d[b+4+k], 16'hB000 + 16'(k));
      chk("bst_a", obs_a[b+4+k], 16'h0100 + 16'(2 * k));
    end
    chk("bst_rdy_lo1", 16'(obs_r[b+1]), 16'h0000);
    chk("bst_rdy_lo11", 16'(obs_r[b+11]), 16'h0000);
    chk("bst_rdy_hi", 16'(obs_r[b+12]), 16'h0001);
    chk("bst_end_v", 16'(obs_v[b+12]), 16'h0000);
    chk("bst_dropped", obs_d[r+4], 16'hB000);
`endif

    idle(4);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
